// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared sizing and legality helpers for the input conditioner
package input_cond_pkg;
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction
  function automatic bit cfg_ok(input int stages, input int filter_cycles);
    return stages >= 2 && filter_cycles >= 1;
  endfunction
endpackage

// File: rtl/input_cond_ch.sv
// input_cond_ch: one channel -- synchroniser, stability filter (INPUT_COND_FILTER_EN) and edge strobes
module input_cond_ch import input_cond_pkg::*; #(
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_async,
  output logic level,
  output logic rise,
  output logic fall
);
  if (!cfg_ok(STAGES, FILTER_CYCLES)) begin : g_bad_cfg
    $error("input_cond_ch: STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end
  logic [STAGES-1:0] s;
  logic sync;
  assign sync = s[STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= {STAGES{RESET_VAL}};
    else s <= {s[STAGES-2:0], in_async};
`ifdef INPUT_COND_FILTER_EN
  localparam int CW = cnt_width(FILTER_CYCLES);
  logic [CW-1:0] cnt;
  logic accept;
  assign accept = (sync != level) && (cnt == CW'(FILTER_CYCLES - 1));
  // Any cycle where sync matches the held level restarts the persistence run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      level <= RESET_VAL;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      level <= accept ? sync : level;
      cnt <= (sync == level || accept) ? '0 : cnt + CW'(1);
      rise <= accept & sync;
      fall <= accept & ~sync;
    end
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      level <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      level <= sync;
      rise <= sync & ~level;
      fall <= ~sync & level;
    end
`endif
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: WIDTH independent synchronise/filter/strobe channels; filter enabled by INPUT_COND_FILTER_EN
module input_conditioner import input_cond_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    input_cond_ch #(
      .STAGES(STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL(RESET_VAL[i])
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .in_async(in_async[i]),
      .level(level[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule
